// File: rtl/vscpu_hv.sv
// rtl/vscpu_hv.sv - Harvard 8-instruction accumulator CPU; `VSCPU_HV_ZFLAG_EN enables the JZ branch
module vscpu_hv #(
    parameter int D_WIDTH      = 8,
    parameter int IA_WIDTH     = 6,
    parameter int DA_WIDTH     = 4,
    parameter int PC_STARTS_AT = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  imem_we,
    input  logic [IA_WIDTH-1:0]   imem_waddr,
    input  logic [IA_WIDTH+2:0]   imem_wdata,
    input  logic                  dmem_we,
    input  logic [DA_WIDTH-1:0]   dmem_waddr,
    input  logic [D_WIDTH-1:0]    dmem_wdata,
    input  logic [DA_WIDTH-1:0]   dmem_raddr,
    output logic [D_WIDTH-1:0]    dmem_rdata,
    output logic                  status,
    output logic [D_WIDTH-1:0]    acc,
    output logic                  carry,
    output logic [IA_WIDTH-1:0]   pc
);
    localparam logic [1:0] ST_HALT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_EXEC  = 2'd3;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_AND = 3'd1;
    localparam logic [2:0] OP_JMP = 3'd2;
    localparam logic [2:0] OP_INC = 3'd3;
    localparam logic [2:0] OP_LDA = 3'd4;
    localparam logic [2:0] OP_STA = 3'd5;
    localparam logic [2:0] OP_JZ  = 3'd6;
    localparam logic [2:0] OP_HLT = 3'd7;

    localparam logic [IA_WIDTH-1:0] LP_PC_START = IA_WIDTH'(PC_STARTS_AT);

    logic [IA_WIDTH+2:0] r_imem [2**IA_WIDTH];
    logic [D_WIDTH-1:0]  r_dmem [2**DA_WIDTH];

    logic [1:0]          r_state;
    logic [IA_WIDTH+2:0] r_ir;
    logic [D_WIDTH-1:0]  r_dr;
    logic [D_WIDTH-1:0]  r_acc;
    logic                r_carry;
    logic [IA_WIDTH-1:0] r_pc;

    logic [2:0]          w_op;
    logic [IA_WIDTH-1:0] w_operand;
    logic [DA_WIDTH-1:0] w_a;
    logic [IA_WIDTH+2:0] w_fetch_word;
    logic [2:0]          w_fetch_op;
    logic [D_WIDTH:0]    w_add_sum;
    logic [D_WIDTH:0]    w_inc_sum;
    logic                w_halted;

    assign w_op         = r_ir[IA_WIDTH+2:IA_WIDTH];
    assign w_operand    = r_ir[IA_WIDTH-1:0];
    assign w_a          = r_ir[DA_WIDTH-1:0];
    assign w_fetch_word = r_imem[r_pc];
    assign w_fetch_op   = w_fetch_word[IA_WIDTH+2:IA_WIDTH];
    assign w_add_sum    = {1'b0, r_acc} + {1'b0, r_dr};
    assign w_inc_sum    = {1'b0, r_acc} + {{D_WIDTH{1'b0}}, 1'b1};
    assign w_halted     = (r_state == ST_HALT);

    assign dmem_rdata = r_dmem[dmem_raddr];
    assign status     = !w_halted;
    assign acc        = r_acc;
    assign carry      = r_carry;
    assign pc         = r_pc;

    // Memories carry no reset; writes are gated by state so an async reset kills a pending STA.
    always_ff @(posedge clock) begin
        if (w_halted && imem_we) begin
            r_imem[imem_waddr] <= imem_wdata;
        end
        if (w_halted) begin
            if (dmem_we) begin
                r_dmem[dmem_waddr] <= dmem_wdata;
            end
        end else if (r_state == ST_EXEC && w_op == OP_STA) begin
            r_dmem[w_a] <= r_acc;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_HALT;
            r_ir    <= '0;
            r_dr    <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_pc    <= LP_PC_START;
        end else begin
            case (r_state)
                ST_HALT: begin
                    if (start) begin
                        r_state <= ST_FETCH;
                        r_pc    <= LP_PC_START;
                        r_carry <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    r_ir <= w_fetch_word;
                    r_pc <= r_pc + 1'b1;
                    if (w_fetch_op == OP_ADD || w_fetch_op == OP_AND || w_fetch_op == OP_LDA) begin
                        r_state <= ST_LOAD;
                    end else begin
                        r_state <= ST_EXEC;
                    end
                end
                ST_LOAD: begin
                    r_dr    <= r_dmem[w_a];
                    r_state <= ST_EXEC;
                end
                default: begin
                    r_state <= ST_FETCH;
                    case (w_op)
                        OP_ADD: {r_carry, r_acc} <= w_add_sum;
                        OP_AND: r_acc <= r_acc & r_dr;
                        OP_JMP: r_pc <= w_operand;
                        OP_INC: {r_carry, r_acc} <= w_inc_sum;
                        OP_LDA: r_acc <= r_dr;
`ifdef VSCPU_HV_ZFLAG_EN
                        OP_JZ: begin
                            if (r_acc == '0) begin
                                r_pc <= w_operand;
                            end
                        end
`endif
                        OP_HLT: r_state <= ST_HALT;
                        default: ;
                    endcase
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vscpu_hv.sv
// tb/tb_vscpu_hv.sv - directed and random program checks of vscpu_hv against an instruction-level model
module tb_vscpu_hv;
    localparam int DW  = 8;
    localparam int IAW = 6;
    localparam int DAW = 4;
    localparam int PCS = 1;
    localparam logic [8:0] I_HLT = 9'h1C0;
    localparam logic [8:0] I_INC = 9'h0C0;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic           imem_we = 1'b0;
    logic [IAW-1:0] imem_waddr = '0;
    logic [IAW+2:0] imem_wdata = '0;
    logic           dmem_we = 1'b0;
    logic [DAW-1:0] dmem_waddr = '0;
    logic [DW-1:0]  dmem_wdata = '0;
    logic [DAW-1:0] dmem_raddr = '0;
    logic [DW-1:0]  dmem_rdata;
    logic           status;
    logic [DW-1:0]  acc;
    logic           carry;
    logic [IAW-1:0] pc;

    vscpu_hv #(.D_WIDTH(DW), .IA_WIDTH(IAW), .DA_WIDTH(DAW), .PC_STARTS_AT(PCS)) dut (
        .clock(clock), .reset(reset), .start(start),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .dmem_we(dmem_we), .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata),
        .dmem_raddr(dmem_raddr), .dmem_rdata(dmem_rdata),
        .status(status), .acc(acc), .carry(carry), .pc(pc)
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;

    logic [8:0] m_imem [64];
    logic [7:0] m_dmem [16];
    logic [7:0] m_acc   = '0;
    logic       m_carry = 1'b0;
    logic [5:0] m_pc    = 6'(PCS);
    int         m_cycles;
    int         last_cycles;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic imem_wr(input logic [5:0] a, input logic [8:0] d);
        imem_we = 1'b1; imem_waddr = a; imem_wdata = d;
        tick();
        imem_we = 1'b0;
        m_imem[a] = d;
    endtask

    task automatic dmem_wr(input logic [3:0] a, input logic [7:0] d);
        dmem_we = 1'b1; dmem_waddr = a; dmem_wdata = d;
        tick();
        dmem_we = 1'b0;
        m_dmem[a] = d;
    endtask

    task automatic dmem_rd(input logic [3:0] a, output logic [7:0] d);
        dmem_raddr = a;
        #1;
        d = dmem_rdata;
    endtask

    // Executes whole instructions until HLT, accumulating the per-instruction cycle cost.
    task automatic model_run();
        logic [8:0] w;
        logic [3:0] a;
        int s;
        m_pc = 6'(PCS);
        m_carry = 1'b0;
        m_cycles = 0;
        for (int n = 0; n < 1000; n++) begin
            w = m_imem[m_pc];
            a = w[3:0];
            m_pc = m_pc + 6'd1;
            case (w[8:6])
                3'd0: begin s = int'(m_acc) + int'(m_dmem[a]); m_carry = (s > 255); m_acc = 8'(s); m_cycles += 3; end
                3'd1: begin m_acc = m_acc & m_dmem[a]; m_cycles += 3; end
                3'd2: begin m_pc = w[5:0]; m_cycles += 2; end
                3'd3: begin s = int'(m_acc) + 1; m_carry = (s > 255); m_acc = 8'(s); m_cycles += 2; end
                3'd4: begin m_acc = m_dmem[a]; m_cycles += 3; end
                3'd5: begin m_dmem[a] = m_acc; m_cycles += 2; end
                3'd6: begin
`ifdef VSCPU_HV_ZFLAG_EN
                    if (m_acc == 8'd0) m_pc = w[5:0];
`endif
                    m_cycles += 2;
                end
                default: begin m_cycles += 2; break; end
            endcase
        end
    endtask

    // Writes imem[PCS] on the same edge that start is sampled, then runs to HLT and compares.
    task automatic run_and_check(input string tag, input logic [8:0] first_word, input bit disturb);
        int cnt;
        logic [7:0] d;
        m_imem[PCS] = first_word;
        model_run();
        start = 1'b1; imem_we = 1'b1; imem_waddr = 6'(PCS); imem_wdata = first_word;
        tick();
        start = 1'b0; imem_we = 1'b0;
        check({tag, "_status_rise"}, 32'(status), 32'd1);
        cnt = 0;
        if (disturb) begin
            dmem_we = 1'b1; dmem_waddr = 4'd5; dmem_wdata = 8'hAA;
            imem_we = 1'b1; imem_waddr = 6'd7; imem_wdata = I_INC;
            start = 1'b1;
            tick(); cnt++;
            dmem_we = 1'b0; imem_we = 1'b0; start = 1'b0;
        end
        while (status === 1'b1 && cnt < 2000) begin
            tick();
            cnt++;
        end
        last_cycles = cnt;
        check({tag, "_cycles"}, 32'(cnt), 32'(m_cycles));
        check({tag, "_acc"}, 32'(acc), 32'(m_acc));
        check({tag, "_carry"}, 32'(carry), 32'(m_carry));
        check({tag, "_pc"}, 32'(pc), 32'(m_pc));
        for (int i = 0; i < 16; i++) begin
            dmem_rd(4'(i), d);
            check($sformatf("%s_dmem%0d", tag, i), 32'(d), 32'(m_dmem[i]));
        end
    endtask

    task automatic reset_pulse_between_edges(input string tag);
        #2 reset = 1'b0;
        #1;
        check({tag, "_status"}, 32'(status), 32'd0);
        check({tag, "_acc"}, 32'(acc), 32'd0);
        check({tag, "_carry"}, 32'(carry), 32'd0);
        check({tag, "_pc"}, 32'(pc), 32'(PCS));
        #1 reset = 1'b1;
        m_acc = '0; m_carry = 1'b0; m_pc = 6'(PCS);
    endtask

    initial begin
        logic [7:0] d;
        int len;
        logic [2:0] op;
        logic [5:0] opr;
        logic [8:0] first;

        repeat (3) tick();
        check("reset_status", 32'(status), 32'd0);
        check("reset_acc", 32'(acc), 32'd0);
        check("reset_carry", 32'(carry), 32'd0);
        check("reset_pc", 32'(pc), 32'(PCS));
        reset = 1'b1;
        tick();

        for (int i = 0; i < 64; i++) imem_wr(6'(i), I_HLT);
        for (int i = 0; i < 16; i++) dmem_wr(4'(i), 8'h00);

        // Basic program
        imem_wr(6'd2, 9'h006); imem_wr(6'd3, 9'h147); imem_wr(6'd4, I_HLT);
        dmem_wr(4'd5, 8'h27); dmem_wr(4'd6, 8'h39);
        run_and_check("basic", 9'h105, 1'b0);
        check("basic_acc_const", 32'(acc), 32'h60);
        check("basic_carry_const", 32'(carry), 32'd0);
        check("basic_status_len", 32'(last_cycles), 32'd10);
        dmem_rd(4'd7, d);
        check("basic_dmem7_const", 32'(d), 32'h60);

        reset_pulse_between_edges("async_reset");

        // Carry and branch
        imem_wr(6'd2, I_INC); imem_wr(6'd3, 9'h186); imem_wr(6'd4, I_HLT); imem_wr(6'd6, I_HLT);
        dmem_wr(4'd5, 8'hFF);
        run_and_check("carry_jz", 9'h105, 1'b0);
        check("carry_jz_acc_const", 32'(acc), 32'h00);
        check("carry_jz_carry_const", 32'(carry), 32'd1);
`ifdef VSCPU_HV_ZFLAG_EN
        check("carry_jz_pc_const", 32'(pc), 32'd7);
`else
        check("carry_jz_pc_const", 32'(pc), 32'd5);
`endif

        // Endless INC/JMP loop: one INC every 4 cycles, carry cleared by start
        imem_wr(6'd1, I_INC); imem_wr(6'd2, 9'h081);
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            tick();
            if (k % 4 == 0) check($sformatf("loop_pc_%0d", k), 32'(pc), 32'd1);
        end
        check("loop_acc", 32'(acc), 32'(8'(m_acc + 8'd20)));
        check("loop_carry", 32'(carry), 32'd0);
        check("loop_status", 32'(status), 32'd1);
        reset_pulse_between_edges("loop_reset");

        // pc wraps from 63 to 0
        imem_wr(6'd63, I_INC); imem_wr(6'd0, I_HLT);
        run_and_check("wrap", 9'h0BF, 1'b0);
        check("wrap_pc_const", 32'(pc), 32'd1);
        imem_wr(6'd0, I_HLT); imem_wr(6'd63, I_HLT);

        // Host writes and start ignored while running
        for (int i = 2; i <= 6; i++) imem_wr(6'(i), I_INC);
        imem_wr(6'd7, I_HLT);
        dmem_wr(4'd5, 8'h11);
        run_and_check("busy_wr", I_INC, 1'b1);
        dmem_rd(4'd5, d);
        check("busy_wr_dmem5", 32'(d), 32'h11);
        dmem_wr(4'd5, 8'hAA);
        dmem_rd(4'd5, d);
        check("halt_wr_dmem5", 32'(d), 32'hAA);

        // Reset during LOAD of ADD, then rerun
        imem_wr(6'd1, 9'h006); imem_wr(6'd2, 9'h147); imem_wr(6'd3, I_HLT);
        dmem_wr(4'd6, 8'h5C);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        reset_pulse_between_edges("midrun_reset");
        dmem_rd(4'd7, d);
        check("midrun_no_sta", 32'(d), 32'(m_dmem[7]));
        run_and_check("rerun", 9'h006, 1'b0);

        // Random forward-only programs
        for (int r = 0; r < 20; r++) begin
            len = $urandom_range(3, 12);
            for (int k = 0; k < 3; k++) dmem_wr(4'($urandom_range(0, 15)), 8'($urandom));
            first = I_HLT;
            for (int i = 1; i <= len; i++) begin
                op = 3'($urandom_range(0, 6));
                if (op == 3'd2 || op == 3'd6) opr = 6'($urandom_range(i + 1, len + 1));
                else opr = 6'($urandom_range(0, 63));
                if (i == PCS) first = {op, opr};
                else imem_wr(6'(i), {op, opr});
            end
            imem_wr(6'(len + 1), I_HLT);
            run_and_check($sformatf("rand%0d", r), first, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
